// File: rtl/apb_arbiter.sv
// apb_arbiter
//   Round-robin arbiter that shares one APB master port between NUM_REQ
//   requesters. Runs the IDLE -> SETUP -> ACCESS protocol for the winner and
//   returns read data, error status and a single-cycle ack. ACCESS phases that
//   run TIMEOUT cycles without PREADY are aborted with an error (TIMEOUT=0
//   disables the abort).
//
// Ports
//   PCLK, PRESETn         clock, asynchronous active-low reset
//   req_valid/req_write   per-requester request and direction (1 = write)
//   req_addr/req_wdata    packed per-requester address / write data
//   req_ack               one-hot, one-cycle completion pulse
//   rsp_rdata/rsp_err     response of the last completion (held until the next)
//   PSEL..PWDATA          APB master outputs
//   PRDATA/PREADY/PSLVERR APB slave responses
//
// state  | meaning
// IDLE   | no transfer; arbitrate unless an ack is being presented this cycle
// SETUP  | PSEL=1, PENABLE=0, one cycle
// ACCESS | PSEL=1, PENABLE=1, wait for PREADY or timeout
module apb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [CNT_W-1:0] to_cnt;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] rr_next;
  logic             timeout_hit;
  int               cand;

  // Search upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!arb_found && req_valid[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign rr_next     = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign timeout_hit = (TIMEOUT > 0) && (to_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      to_cnt    <= '0;
      req_ack   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        ST_IDLE: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          // Skip arbitration while the previous ack is visible, so the acked
          // requester has one cycle to withdraw before being considered again.
          if (arb_found && (req_ack == '0)) begin
            winner <= arb_idx;
            PADDR  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            PWDATA <= req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
            PWRITE <= req_write[arb_idx];
            PSEL   <= 1'b1;
            to_cnt <= '0;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          // Counting starts here so the first ACCESS cycle sees a count of 1.
          if (!timeout_hit && TIMEOUT > 0) to_cnt <= to_cnt + 1'b1;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY || timeout_hit) begin
            PSEL            <= 1'b0;
            PENABLE         <= 1'b0;
            req_ack[winner] <= 1'b1;
            rsp_err         <= PREADY ? PSLVERR : 1'b1;
            rsp_rdata       <= (PREADY && !PWRITE) ? PRDATA : '0;
            rr_ptr          <= rr_next;
            state           <= ST_IDLE;
          end else if (TIMEOUT > 0) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter
//   Directed and randomized transfers for apb_arbiter (2 requesters,
//   TIMEOUT=4). A small APB slave answers after a programmable number of wait
//   cycles; expected grants, latencies and responses come from a
//   transaction-level round-robin model.
module tb_apb_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic             PCLK = 1'b0;
  logic             PRESETn = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ack;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             PSEL, PENABLE, PWRITE;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic [DW-1:0]    PRDATA;
  logic             PREADY, PSLVERR;

  logic [AW-1:0]    tb_addr  [NR];
  logic [DW-1:0]    tb_wdata [NR];

  assign req_addr  = {tb_addr[1], tb_addr[0]};
  assign req_wdata = {tb_wdata[1], tb_wdata[0]};

  apb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int          checks = 0;
  int          failures = 0;
  int          rr_model = 0;
  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt = 0;

  // APB slave: PREADY rises on ACCESS cycle slv_wait+1.
  initial begin
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) acc_cnt++;
      else acc_cnt = 0;
      if (acc_cnt > slv_wait) begin
        PREADY = 1'b1; PRDATA = slv_rdata; PSLVERR = slv_err;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  function automatic int pick(input int rr, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(rr + k) % NR]) return (rr + k) % NR;
    end
    return -1;
  endfunction

  // Runs one transfer with the requests currently driven. Expected results
  // come from the round-robin model and the slave's wait setting.
  task automatic xfer(input int w, input logic e, input logic [31:0] rd,
                      input string tag, input bit drop, output int won);
    int            exp_win, cyc, first_psel, pe_cnt, ps_cnt, acc_cycles;
    bit            got, is_to;
    logic [NR-1:0] exp_ack;
    exp_win = pick(rr_model, req_valid);
    slv_wait = w; slv_err = e; slv_rdata = rd;
    got = 0; cyc = 0; first_psel = 0; pe_cnt = 0; ps_cnt = 0; won = -1;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (req_ack != '0) got = 1;
      else begin
        if (PSEL) begin
          ps_cnt++;
          if (first_psel == 0) first_psel = cyc;
        end
        if (PENABLE) pe_cnt++;
      end
    end
    for (int i = 0; i < NR; i++) if (req_ack[i]) won = i;
    is_to      = (w >= TO);
    acc_cycles = is_to ? TO : w + 1;
    exp_ack    = '0;
    exp_ack[exp_win] = 1'b1;
    chk({tag, "_ack_seen"}, 64'(got), 64'(1));
    chk({tag, "_ack"}, 64'(req_ack), 64'(exp_ack));
    chk({tag, "_latency"}, 64'(cyc), 64'(acc_cycles + 2));
    chk({tag, "_psel_first"}, 64'(first_psel), 64'(1));
    chk({tag, "_psel_cycles"}, 64'(ps_cnt), 64'(acc_cycles + 1));
    chk({tag, "_penable_cycles"}, 64'(pe_cnt), 64'(acc_cycles));
    chk({tag, "_psel_drop"}, 64'(PSEL), 64'(0));
    chk({tag, "_rdata"}, 64'(rsp_rdata),
        64'((is_to || req_write[exp_win]) ? 32'h0 : rd));
    chk({tag, "_err"}, 64'(rsp_err), 64'(is_to ? 1'b1 : e));
    chk({tag, "_paddr"}, 64'(PADDR), 64'(tb_addr[exp_win]));
    chk({tag, "_pwrite"}, 64'(PWRITE), 64'(req_write[exp_win]));
    chk({tag, "_pwdata"}, 64'(PWDATA), 64'(tb_wdata[exp_win]));
    rr_model = (exp_win + 1) % NR;
    if (drop) req_valid = '0;
    tick();
    chk({tag, "_ack_pulse"}, 64'(req_ack), 64'(0));
  endtask

  initial begin
    int          won;
    logic [31:0] rd;
    req_valid = '0; req_write = '0;
    for (int i = 0; i < NR; i++) begin tb_addr[i] = '0; tb_wdata[i] = '0; end

    // Reset state
    PRESETn = 1'b0;
    repeat (3) tick();
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_ack", 64'(req_ack), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_err", 64'(rsp_err), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Contention from reset: both held, expect 0,1,0,1
    tb_addr[0] = 32'h100; tb_addr[1] = 32'h104;
    tb_wdata[0] = 32'h1111_0000; tb_wdata[1] = 32'h2222_0000;
    req_write = 2'b00;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      xfer(i, 1'b0, $urandom, "cont", 1'b0, won);
      chk("cont_order", 64'(won), 64'(i % 2));
    end

    // Single write
    req_valid = 2'b01; req_write = 2'b01;
    tb_addr[0] = 32'h10; tb_wdata[0] = 32'hA5A5_0001;
    xfer(0, 1'b0, $urandom, "wr1", 1'b1, won);

    // Read with three wait cycles
    req_valid = 2'b10; req_write = 2'b00;
    tb_addr[1] = 32'h20;
    xfer(3, 1'b0, 32'hDEAD_BEEF, "rd_wait", 1'b1, won);

    // Slave error, then a normal transfer
    req_valid = 2'b01; req_write = 2'b01;
    tb_addr[0] = 32'h30; tb_wdata[0] = 32'h0BAD_F00D;
    xfer(0, 1'b1, $urandom, "slverr", 1'b1, won);
    req_valid = 2'b10; req_write = 2'b00; tb_addr[1] = 32'h34;
    xfer(1, 1'b0, 32'h1234_5678, "after_err", 1'b1, won);

    // Timeout: slave never ready
    req_valid = 2'b01; req_write = 2'b00; tb_addr[0] = 32'h40;
    xfer(50, 1'b0, 32'hFFFF_FFFF, "timeout", 1'b1, won);

    // Randomized transfers
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NR; i++) begin
        tb_addr[i]  = $urandom;
        tb_wdata[i] = $urandom;
      end
      req_write = NR'($urandom_range(0, 3));
      req_valid = NR'($urandom_range(1, 3));
      rd = $urandom;
      xfer(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), rd, "rand", 1'b1, won);
    end

    // Reset during ACCESS
    req_valid = 2'b10; req_write = 2'b00; tb_addr[1] = 32'h50;
    slv_wait = 100;
    tick();
    tick();
    chk("rst_mid_in_access", 64'(PENABLE), 64'(1));
    #2;
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", 64'(PSEL), 64'(0));
    chk("rst_mid_penable", 64'(PENABLE), 64'(0));
    chk("rst_mid_ack", 64'(req_ack), 64'(0));
    tick();
    tick();
    chk("rst_mid_no_ack", 64'(req_ack), 64'(0));
    req_valid = '0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    rr_model = 0;
    tb_addr[0] = 32'h60; tb_addr[1] = 32'h64;
    req_valid = 2'b11;
    xfer(0, 1'b0, $urandom, "post_rst", 1'b1, won);
    chk("post_rst_first_grant", 64'(won), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
